// File: rtl/spram_readout.sv
// rtl/spram_readout.sv - reads a contiguous SPRAM word range and streams it out on valid/ready
//
// Purpose: owns the SB_SPRAM256KA port in read mode. On start it issues reads
//   from base_addr for length words, absorbs the 1-cycle SPRAM read latency and
//   downstream backpressure in a small output buffer, and presents the words in
//   address order with m_last on the final one.
// Ports:
//   clock, resetn       single clock (posedge), asynchronous active-low reset
//   start               1-cycle request, samples base_addr/length when idle
//   base_addr, length   first word address, word count (0..2^ADDR_W)
//   busy, done          transfer in progress, 1-cycle completion pulse
//   spram_addr/cs/wren  SPRAM ADDRESS, CHIPSELECT, WREN (always 0)
//   spram_dout          SPRAM DATAOUT, valid the cycle after an issue
//   m_valid/m_data/m_last/m_ready   output word stream
`timescale 1ns/1ps
module spram_readout #(
  parameter int ADDR_W    = 14,
  parameter int DATA_W    = 16,
  parameter int BUF_DEPTH = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] spram_addr,
  output logic              spram_cs,
  output logic              spram_wren,
  input  logic [DATA_W-1:0] spram_dout,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  input  logic              m_ready
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 2;
  localparam logic [ADDR_W:0]   LEN_ONE  = 1;
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [PTR_W-1:0]  PTR_ONE  = 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [ADDR_W:0]   r_len;
  logic [ADDR_W:0]   r_issued;
  logic [ADDR_W-1:0] r_next_addr;
  logic [ADDR_W-1:0] r_spram_addr;
  // Read pipeline: r_cs marks the SPRAM issue cycle, r_cap the following
  // cycle in which spram_dout holds the word and is pushed into the buffer.
  logic              r_cs;
  logic              r_cs_last;
  logic              r_cap;
  logic              r_cap_last;

  // Buffer entries carry the last-word flag alongside the data.
  logic [DATA_W:0]   r_buf [BUF_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              r_m_valid;
  logic [DATA_W-1:0] r_m_data;
  logic              r_m_last;
  logic              r_done;

  logic              w_pop;
  logic              w_push;
  logic              w_room;
  logic              w_issue;
  logic              w_issue_last;
  logic              w_final;
  logic              w_accept;
  logic [CNT_W-1:0]  w_commit;
  logic [CNT_W-1:0]  w_count_kept;
  logic [CNT_W-1:0]  w_count_next;
  logic [PTR_W-1:0]  w_rd_next;
  logic [DATA_W:0]   w_head_next;

  always_comb begin
    w_pop        = r_m_valid && m_ready;
    w_push       = r_cap;
    // Every word already buffered or still in the read pipeline has a slot
    // reserved; a new read may issue only if a slot remains after this pop.
    w_commit     = r_count + CNT_W'(r_cs) + CNT_W'(r_cap) - CNT_W'(w_pop);
    w_room       = w_commit < CNT_W'(BUF_DEPTH);
    w_issue      = (r_state == S_READ) && (r_issued != r_len) && w_room;
    w_issue_last = (r_issued == r_len - LEN_ONE);
    w_final      = w_pop && r_m_last;
    w_accept     = (r_state == S_IDLE) && start;
    w_count_kept = r_count - CNT_W'(w_pop);
    w_count_next = w_count_kept + CNT_W'(w_push);
    w_rd_next    = r_rd_ptr + PTR_W'(w_pop);
    // When the buffer drains to empty this cycle, the word being captured
    // becomes the new head directly.
    w_head_next  = (w_count_kept == '0) ? {r_cap_last, spram_dout} : r_buf[w_rd_next];
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start && (length != '0)) w_state_next = S_READ;
      S_READ:  if (w_issue && w_issue_last) w_state_next = S_DRAIN;
      S_DRAIN: if (w_final) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_len        <= '0;
      r_issued     <= '0;
      r_next_addr  <= '0;
      r_spram_addr <= '0;
      r_cs         <= 1'b0;
      r_cs_last    <= 1'b0;
      r_cap        <= 1'b0;
      r_cap_last   <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_m_valid    <= 1'b0;
      r_m_data     <= '0;
      r_m_last     <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= (w_accept && (length == '0)) || ((r_state == S_DRAIN) && w_final);

      if (w_accept) begin
        r_len       <= length;
        r_issued    <= '0;
        r_next_addr <= base_addr;
      end else if (w_issue) begin
        r_issued    <= r_issued + LEN_ONE;
        r_next_addr <= r_next_addr + ADDR_ONE;
      end

      r_cs       <= w_issue;
      r_cs_last  <= w_issue && w_issue_last;
      if (w_issue) r_spram_addr <= r_next_addr;
      r_cap      <= r_cs;
      r_cap_last <= r_cs_last;

      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      r_rd_ptr  <= w_rd_next;
      r_count   <= w_count_next;

      r_m_valid <= (w_count_next != '0);
      if (w_count_next != '0) begin
        r_m_data <= w_head_next[DATA_W-1:0];
        r_m_last <= w_head_next[DATA_W];
      end else begin
        r_m_last <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_buf[r_wr_ptr] <= {r_cap_last, spram_dout};
  end

  assign busy       = (r_state != S_IDLE);
  assign done       = r_done;
  assign spram_addr = r_spram_addr;
  assign spram_cs   = r_cs;
  assign spram_wren = 1'b0;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_last     = r_m_last;

endmodule
